// File: rtl/lfsr_gf56_rewind_if.sv
// Request/response bundle for the GF(2^56) counter rewinder.
// The master side issues requests and consumes results. The slave side is the rewinder.
interface lfsr_gf56_rewind_if #(
  parameter int unsigned STEP_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [55:0]       ctr_in;
  logic [STEP_W-1:0] nsteps;
  logic [7:0]        domain;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       so;
  logic              busy;

  modport master (
    output in_valid, ctr_in, nsteps, domain, out_ready,
    input  in_ready, out_valid, so, busy
  );

  modport slave (
    input  in_valid, ctr_in, nsteps, domain, out_ready,
    output in_ready, out_valid, so, busy
  );
endinterface

// File: rtl/lfsr_gf56_rewind.sv
// Steps the Romulus 56-bit block-counter LFSR (x^56+x^7+x^4+x^2+1) backward, one step per clock.
// The result is returned in wire format as {counter, domain}.
module lfsr_gf56_rewind #(
  parameter int unsigned STEP_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  lfsr_gf56_rewind_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [55:0]       st_q, st_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [7:0]        dom_q, dom_d;
  logic [63:0]       so_q, so_d;

  // The wire/logical byte order swap is its own inverse.
  function automatic logic [55:0] swap56(input logic [55:0] v);
    logic [55:0] r;
    for (int unsigned b = 0; b < 7; b++) begin
      r[8*b +: 8] = v[8*(6-b) +: 8];
    end
    return r;
  endfunction

  function automatic logic [55:0] inv_step(input logic [55:0] n);
    logic [55:0] p;
    p    = {n[0], n[55:1]};
    p[1] = p[1] ^ n[0];
    p[3] = p[3] ^ n[0];
    p[6] = p[6] ^ n[0];
    return p;
  endfunction

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    dom_d   = dom_q;
    so_d    = so_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            st_d    = swap56(bus.ctr_in);
            cnt_d   = bus.nsteps;
            dom_d   = bus.domain;
            state_d = (bus.nsteps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          st_d  = inv_step(st_q);
          cnt_d = cnt_q - STEP_W'(1);
          if (cnt_q == STEP_W'(1)) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The result is captured once on entry to DONE so it stays put under backpressure and afterwards.
    if (state_d == DONE && state_q != DONE) begin
      so_d = {swap56(st_d), dom_d};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
      dom_q   <= '0;
      so_q    <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      dom_q   <= dom_d;
      so_q    <= so_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.so        = so_q;

endmodule

// File: tb/tb_lfsr_gf56_rewind.sv
// Directed bench for lfsr_gf56_rewind: known vectors, forward-stepper round trips,
// backpressure, abort and asynchronous reset.
module tb_lfsr_gf56_rewind;

  logic clk;
  logic rst_n;
  logic abort;
  int unsigned n_checks;
  int unsigned n_errors;

  lfsr_gf56_rewind_if #(.STEP_W(16)) bus ();

  lfsr_gf56_rewind #(.STEP_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (abort),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [55:0] wl(input logic [55:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24], w[39:32], w[47:40], w[55:48]};
  endfunction

  // Forward step of the Romulus counter LFSR, in logical form.
  function automatic logic [55:0] fwd(input logic [55:0] l);
    logic [55:0] n;
    n    = {l[54:0], l[55]};
    n[2] = n[2] ^ l[55];
    n[4] = n[4] ^ l[55];
    n[7] = n[7] ^ l[55];
    return n;
  endfunction

  // Issues one request from IDLE, waits for the result and accepts it immediately.
  // lat counts clock edges from the accepting edge up to the first cycle with out_valid.
  task automatic run_req(input logic [55:0] ctr, input int unsigned n, input logic [7:0] dom,
                         output logic [63:0] res, output int unsigned lat);
    int unsigned budget;
    budget = n + 10;
    check("in_ready_before_req", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.ctr_in   = ctr;
    bus.nsteps   = 16'(n);
    bus.domain   = dom;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_within_budget", 64'(bus.out_valid), 64'(1));
    res = bus.so;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after_accept", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    logic [55:0] x;
    logic [55:0] y;
    int unsigned lat;
    int unsigned n;
    logic seen;

    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ctr_in    = '0;
    bus.nsteps    = '0;
    bus.domain    = '0;
    bus.out_ready = 1'b0;

    #1;
    check("reset_in_ready", 64'(bus.in_ready), 64'(1));
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_so", bus.so, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed vectors.
    run_req(56'h01000000000000, 1, 8'h1A, res, lat);
    check("l1_n1_so", res, 64'h4A0000000000801A);
    check("l1_n1_lat", 64'(lat), 64'(2));
    run_req(56'h02000000000000, 2, 8'h00, res, lat);
    check("l2_n2_so", res, 64'h4A00000000008000);
    check("l2_n2_lat", 64'(lat), 64'(3));
    run_req(56'h02000000000000, 1, 8'h00, res, lat);
    check("l2_n1_so", res, 64'h0100000000000000);
    run_req(56'h00000000000040, 0, 8'h5C, res, lat);
    check("n0_passthru_so", res, 64'h000000000000405C);
    check("n0_lat", 64'(lat), 64'(1));
    run_req(56'h00000000000040, 1, 8'h5C, res, lat);
    check("top_bit_n1_so", res, 64'h000000000000205C);

    // Round trips through the forward stepper.
    for (int k = 0; k < 4; k++) begin
      x = 56'({$urandom(), $urandom()});
      n = $urandom_range(300, 1);
      run_req(x, n, 8'(k), res, lat);
      y = wl(res[63:8]);
      for (int unsigned i = 0; i < n; i++) y = fwd(y);
      check("roundtrip_ctr", 64'(y), 64'(wl(x)));
      check("roundtrip_dom", 64'(res[7:0]), 64'(k));
      check("roundtrip_lat", 64'(lat), 64'(n + 1));
    end

    run_req(56'h0, 1000, 8'hA5, res, lat);
    check("zero_fixed_point", res, 64'h00000000000000A5);
    check("zero_lat", 64'(lat), 64'(1001));

    // Largest step count must run all the way without cnt wrapping.
    run_req(56'h01000000000000, 65535, 8'h3C, res, lat);
    y = wl(res[63:8]);
    for (int unsigned i = 0; i < 65535; i++) y = fwd(y);
    check("max_steps_roundtrip", 64'(y), 64'h1);
    check("max_steps_lat", 64'(lat), 64'(65536));

    // Backpressure, with an in_valid pulse during RUN that must be ignored.
    bus.in_valid = 1'b1;
    bus.ctr_in   = 56'h02000000000000;
    bus.nsteps   = 16'd3;
    bus.domain   = 8'h33;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_busy_run", 64'(bus.busy), 64'(1));
    check("bp_in_ready_run", 64'(bus.in_ready), 64'(0));
    bus.in_valid = 1'b1;
    bus.ctr_in   = 56'h01000000000000;
    bus.nsteps   = 16'd0;
    bus.domain   = 8'hEE;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("bp_out_valid", 64'(bus.out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      check("bp_so_stable", bus.so, 64'h2500000000004033);
      check("bp_in_ready_done", 64'(bus.in_ready), 64'(0));
      @(negedge clk);
    end
    check("bp_still_valid", 64'(bus.out_valid), 64'(1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_released_valid", 64'(bus.out_valid), 64'(0));
    check("bp_released_ready", 64'(bus.in_ready), 64'(1));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen |= bus.out_valid | bus.busy;
      @(negedge clk);
    end
    check("bp_pulse_dropped", 64'(seen), 64'(0));

    // Abort in the third RUN cycle.
    bus.in_valid = 1'b1;
    bus.ctr_in   = 56'h00FF00FF00FF00;
    bus.nsteps   = 16'd10;
    bus.domain   = 8'h11;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_run_in_ready", 64'(bus.in_ready), 64'(1));
    check("abort_run_busy", 64'(bus.busy), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    check("abort_run_no_output", 64'(seen), 64'(0));

    // abort and in_valid together in IDLE: nothing is accepted.
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.nsteps   = 16'd0;
    @(negedge clk);
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_idle_busy", 64'(bus.busy), 64'(0));
    check("abort_idle_out_valid", 64'(bus.out_valid), 64'(0));

    // Abort while holding a result drops out_valid but leaves so alone.
    bus.in_valid = 1'b1;
    bus.ctr_in   = 56'h123456789ABCDE;
    bus.nsteps   = 16'd0;
    bus.domain   = 8'h77;
    @(negedge clk);
    bus.in_valid = 1'b0;
    held = bus.so;
    check("abort_done_pre_valid", 64'(bus.out_valid), 64'(1));
    check("abort_done_pre_so", held, 64'h123456789ABCDE77);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_valid", 64'(bus.out_valid), 64'(0));
    check("abort_done_so_held", bus.so, 64'h123456789ABCDE77);

    // Asynchronous reset in the middle of RUN.
    bus.in_valid = 1'b1;
    bus.ctr_in   = 56'h01000000000000;
    bus.nsteps   = 16'd50;
    bus.domain   = 8'h42;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("async_rst_busy", 64'(bus.busy), 64'(0));
    check("async_rst_so", bus.so, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_req(56'h01000000000000, 1, 8'h1A, res, lat);
    check("post_reset_so", res, 64'h4A0000000000801A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
